vga_scan_out: RTL and testbench

- VGA raster timing generator and video output stage: the display end of the x/y/pixel interface that game and graphics blocks consume and produce.
- Drives scan coordinates to the pixel source, takes back a 1-bit pixel after a fixed latency, and emits hsync, vsync and 6-bit RGB for the TinyTapeout VGA PMOD.
- Also provides frame_start and vblank so game logic can update once per frame.

---
 rtl/vga_scan_out.sv | 121 ++++++++++++
 tb/tb_vga_scan_out.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_out.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_out
// Brief    : VGA raster timing generator with a latency-aligned sync/RGB
//            output stage for a 1-bit pixel source.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_out #(
    parameter int         H_VISIBLE     = 640,
    parameter int         H_FRONT       = 16,
    parameter int         H_SYNC        = 96,
    parameter int         H_BACK        = 48,
    parameter int         V_VISIBLE     = 480,
    parameter int         V_FRONT       = 10,
    parameter int         V_SYNC        = 2,
    parameter int         V_BACK        = 33,
    parameter int         PIXEL_LATENCY = 1,
    parameter logic       SYNC_POL      = 1'b0,
    parameter logic [5:0] FG_COLOR      = 6'b111111,
    parameter logic [5:0] BG_COLOR      = 6'b000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_ce,
    input  logic       pixel_in,
    output logic [9:0] x,
    output logic [8:0] y,
    output logic       video_active,
    output logic       vblank,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [5:0] rgb
);

    localparam logic [9:0] c_H_VIS   = 10'(H_VISIBLE);
    localparam logic [9:0] c_HS_BEG  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] c_HS_END  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] c_H_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] c_V_VIS   = 10'(V_VISIBLE);
    localparam logic [9:0] c_VS_BEG  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] c_VS_END  = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [9:0] c_V_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       w_act;
    logic       w_hs;
    logic       w_vs;
    logic       w_act_d;
    logic       w_hs_d;
    logic       w_vs_d;
    logic       r_hsync;
    logic       r_vsync;
    logic [5:0] r_rgb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (pix_ce) begin
            if (r_h_cnt == c_H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == c_V_LAST) ? 10'd0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    assign w_act = (r_h_cnt < c_H_VIS) && (r_v_cnt < c_V_VIS);
    assign w_hs  = (r_h_cnt >= c_HS_BEG) && (r_h_cnt < c_HS_END);
    assign w_vs  = (r_v_cnt >= c_VS_BEG) && (r_v_cnt < c_VS_END);

    // Coordinates read as zero anywhere outside the visible rectangle.
    assign x            = w_act ? r_h_cnt : 10'd0;
    assign y            = w_act ? r_v_cnt[8:0] : 9'd0;
    assign video_active = w_act;
    assign vblank       = (r_v_cnt >= c_V_VIS);
    assign frame_start  = pix_ce && (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

    // Delay decode by the pixel source latency so it meets pixel_in in step.
    if (PIXEL_LATENCY == 0) begin : g_bypass
        assign w_act_d = w_act;
        assign w_hs_d  = w_hs;
        assign w_vs_d  = w_vs;
    end else begin : g_delay
        logic [PIXEL_LATENCY-1:0][2:0] r_pipe;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_pipe <= '0;
            end else if (pix_ce) begin
                r_pipe[0] <= {w_act, w_hs, w_vs};
                for (int i = 1; i < PIXEL_LATENCY; i++) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
            end
        end

        assign {w_act_d, w_hs_d, w_vs_d} = r_pipe[PIXEL_LATENCY-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hsync <= ~SYNC_POL;
            r_vsync <= ~SYNC_POL;
            r_rgb   <= 6'd0;
        end else if (pix_ce) begin
            r_hsync <= w_hs_d ? SYNC_POL : ~SYNC_POL;
            r_vsync <= w_vs_d ? SYNC_POL : ~SYNC_POL;
            r_rgb   <= w_act_d ? (pixel_in ? FG_COLOR : BG_COLOR) : 6'd0;
        end
    end

    assign hsync = r_hsync;
    assign vsync = r_vsync;
    assign rgb   = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_scan_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_scan_out
// Brief    : Scoreboarded bench for vga_scan_out at latencies 0/1/3 on a small
//            raster plus one full-size 640x480 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_scan_out;

    localparam int HV = 16, HF = 2, HSY = 4, HB = 3;
    localparam int VV = 10, VF = 2, VSY = 2, VB = 3;
    localparam int HT = HV + HF + HSY + HB;
    localparam int VT = VV + VF + VSY + VB;

    logic clk;
    logic rst;
    logic pix_ce;
    logic mode;

    logic [9:0] s_x   [3];
    logic [8:0] s_y   [3];
    logic       s_act [3];
    logic       s_vb  [3];
    logic       s_fs  [3];
    logic       s_hs  [3];
    logic       s_vs  [3];
    logic [5:0] s_rgb [3];
    logic       s_pix [3];

    logic [9:0] f_x;
    logic [8:0] f_y;
    logic       f_act, f_vb, f_fs, f_hs, f_vs;
    logic [5:0] f_rgb;

    int n_tests;
    int n_fail;
    int mh, mv;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q3[$];
    logic [7:0] e_out [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        return (g == 0) ? 0 : ((g == 1) ? 1 : 3);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_small
        localparam int L = (g == 0) ? 0 : ((g == 1) ? 1 : 3);
        logic [3:0] r_src;
        logic       w_match;

        assign w_match = mode | ((s_x[g] == 10'd5) && (s_y[g] == 9'd3));

        always @(posedge clk or posedge rst) begin
            if (rst)         r_src <= 4'd0;
            else if (pix_ce) r_src <= {r_src[2:0], w_match};
        end

        if (L == 0) begin : g_comb
            assign s_pix[g] = w_match;
        end else begin : g_reg
            assign s_pix[g] = r_src[L-1];
        end

        vga_scan_out #(
            .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
            .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
            .PIXEL_LATENCY(L)
        ) u_dut (
            .clk(clk), .rst(rst), .pix_ce(pix_ce), .pixel_in(s_pix[g]),
            .x(s_x[g]), .y(s_y[g]), .video_active(s_act[g]), .vblank(s_vb[g]),
            .frame_start(s_fs[g]), .hsync(s_hs[g]), .vsync(s_vs[g]), .rgb(s_rgb[g])
        );
    end

    vga_scan_out u_full (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .pixel_in(1'b0),
        .x(f_x), .y(f_y), .video_active(f_act), .vblank(f_vb),
        .frame_start(f_fs), .hsync(f_hs), .vsync(f_vs), .rgb(f_rgb)
    );

    // Expected {hsync, vsync, rgb} for a raster position on the small timing.
    function automatic logic [7:0] exp_word(input int h, input int v);
        logic act, hs, vs, pix;
        act = (h < HV) && (v < VV);
        hs  = (h >= HV + HF) && (h < HV + HF + HSY);
        vs  = (v >= VV + VF) && (v < VV + VF + VSY);
        pix = mode || ((h == 5) && (v == 3));
        return {~hs, ~vs, (act && pix) ? 6'h3F : 6'h00};
    endfunction

    task automatic tick(input logic ce);
        pix_ce = ce;
        if (ce) begin
            q0.push_back(exp_word(mh, mv));
            q1.push_back(exp_word(mh, mv));
            q3.push_back(exp_word(mh, mv));
        end
        @(posedge clk);
        #1;
        if (ce) begin
            e_out[0] = q0.pop_front();
            e_out[1] = q1.pop_front();
            e_out[2] = q3.pop_front();
            mh++;
            if (mh == HT) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end
        end
    endtask

    task automatic do_reset();
        pix_ce = 1'b0;
        rst    = 1'b1;
        #1;
        mh = 0;
        mv = 0;
        q0.delete();
        q1.delete();
        q3.delete();
        q1.push_back(8'hC0);
        repeat (3) q3.push_back(8'hC0);
        for (int g = 0; g < 3; g++) e_out[g] = 8'hC0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pix_ce = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) begin
            n_tests++;
            if ({s_hs[g], s_vs[g], s_rgb[g], s_x[g], s_y[g], s_act[g], s_vb[g], s_fs[g]}
                !== {1'b1, 1'b1, 6'd0, 10'd0, 9'd0, 1'b1, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_state dut%0d: hs=%b vs=%b rgb=%h x=%0d y=%0d act=%b vb=%b fs=%b, want 1 1 00 0 0 1 0 0",
                         g, s_hs[g], s_vs[g], s_rgb[g], s_x[g], s_y[g], s_act[g], s_vb[g], s_fs[g]);
            end
        end
        pix_ce = 1'b1;
        #1;
        n_tests++;
        if ({s_fs[1], f_fs, f_hs, f_vs, f_act} !== 5'b11111) begin
            n_fail++;
            $display("FAIL reset_frame_start: fs=%b full_fs=%b full_hs=%b full_vs=%b full_act=%b, want all 1",
                     s_fs[1], f_fs, f_hs, f_vs, f_act);
        end
        mode = 1'b1;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            repeat ((k == 0) ? 135 : 320) tick(1'b1);
            n_tests++;
            if (k == 0 && {s_x[1], s_y[1], s_rgb[1]} !== {10'd10, 9'd5, 6'h3F}) begin
                n_fail++;
                $display("FAIL reset_precheck_active: x=%0d y=%0d rgb=%h, want 10 5 3f", s_x[1], s_y[1], s_rgb[1]);
            end else if (k == 1 && {s_hs[0], s_vs[0]} !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_precheck_sync: hs=%b vs=%b, want 0 0", s_hs[0], s_vs[0]);
            end
            rst = 1'b1;
            #1;
            for (int g = 0; g < 3; g++) begin
                n_tests++;
                if ({s_hs[g], s_vs[g], s_rgb[g], s_x[g], s_y[g]} !== {1'b1, 1'b1, 6'd0, 10'd0, 9'd0}) begin
                    n_fail++;
                    $display("FAIL async_reset%0d dut%0d: hs=%b vs=%b rgb=%h x=%0d y=%0d, want 1 1 00 0 0",
                             k, g, s_hs[g], s_vs[g], s_rgb[g], s_x[g], s_y[g]);
                end
            end
        end
    endtask

    task automatic test_frame_timing();
        int hs_low, vs_low, f_hs_low, fs_cnt, fs_first, fs_last;
        hs_low = 0; vs_low = 0; f_hs_low = 0; fs_cnt = 0; fs_first = 0; fs_last = 0;
        mode = 1'b0;
        do_reset();
        for (int t = 1; t <= 2 * HT * VT + 10; t++) begin
            tick(1'b1);
            for (int g = 0; g < 3; g++) begin
                n_tests++;
                if ({s_hs[g], s_vs[g]} !== e_out[g][7:6]) begin
                    n_fail++;
                    $display("FAIL sync dut%0d tick %0d: hs/vs=%b%b want %b", g, t, s_hs[g], s_vs[g], e_out[g][7:6]);
                end
            end
            if (!s_hs[1]) hs_low++;
            if (!s_vs[1]) vs_low++;
            if (!f_hs) f_hs_low++;
            if (s_fs[1]) begin
                fs_cnt++;
                if (fs_cnt == 1) fs_first = t;
                fs_last = t;
            end
        end
        n_tests++;
        if (hs_low != 2 * VT * HSY || vs_low != 2 * VSY * HT) begin
            n_fail++;
            $display("FAIL sync_widths: hs_low=%0d vs_low=%0d, want %0d %0d", hs_low, vs_low, 2 * VT * HSY, 2 * VSY * HT);
        end
        n_tests++;
        if (f_hs_low != 96) begin
            n_fail++;
            $display("FAIL full_hsync_width: got %0d want 96", f_hs_low);
        end
        n_tests++;
        if (fs_cnt != 2 || fs_last - fs_first != HT * VT) begin
            n_fail++;
            $display("FAIL frame_start_spacing: count=%0d spacing=%0d, want 2 %0d", fs_cnt, fs_last - fs_first, HT * VT);
        end
    endtask

    task automatic test_alignment();
        int hits [3];
        int hit_t [3];
        mode = 1'b0;
        do_reset();
        for (int g = 0; g < 3; g++) begin hits[g] = 0; hit_t[g] = 0; end
        for (int t = 1; t <= HT * VT + 5; t++) begin
            tick(1'b1);
            for (int g = 0; g < 3; g++) begin
                n_tests++;
                if (s_rgb[g] !== e_out[g][5:0]) begin
                    n_fail++;
                    $display("FAIL align_rgb dut%0d tick %0d: got %h want %h", g, t, s_rgb[g], e_out[g][5:0]);
                end
                if (s_rgb[g] == 6'h3F) begin hits[g]++; hit_t[g] = t; end
            end
        end
        for (int g = 0; g < 3; g++) begin
            n_tests++;
            if (hits[g] != 1 || hit_t[g] != 3 * HT + 5 + 1 + lat_of(g)) begin
                n_fail++;
                $display("FAIL align_hit dut%0d: hits=%0d at tick %0d, want 1 at %0d",
                         g, hits[g], hit_t[g], 3 * HT + 5 + 1 + lat_of(g));
            end
        end
    endtask

    task automatic test_blanking();
        int fg [3];
        logic act;
        mode = 1'b1;
        do_reset();
        for (int g = 0; g < 3; g++) fg[g] = 0;
        for (int t = 1; t <= HT * VT + 4; t++) begin
            tick(1'b1);
            act = (mh < HV) && (mv < VV);
            n_tests++;
            if ({s_x[1], s_y[1], s_act[1], s_vb[1]} !== {act ? 10'(mh) : 10'd0, act ? 9'(mv) : 9'd0, act, mv >= VV}) begin
                n_fail++;
                $display("FAIL blank_coords tick %0d: x=%0d y=%0d act=%b vb=%b at h=%0d v=%0d",
                         t, s_x[1], s_y[1], s_act[1], s_vb[1], mh, mv);
            end
            for (int g = 0; g < 3; g++) begin
                n_tests++;
                if (s_rgb[g] !== e_out[g][5:0]) begin
                    n_fail++;
                    $display("FAIL blank_rgb dut%0d tick %0d: got %h want %h", g, t, s_rgb[g], e_out[g][5:0]);
                end
                if (s_rgb[g] == 6'h3F) fg[g]++;
            end
        end
        for (int g = 0; g < 3; g++) begin
            n_tests++;
            if (fg[g] != HV * VV + 4 - lat_of(g)) begin
                n_fail++;
                $display("FAIL blank_fg_count dut%0d: got %0d want %0d", g, fg[g], HV * VV + 4 - lat_of(g));
            end
        end
    endtask

    task automatic test_clock_enable();
        int run_s, max_s, run_f, max_f;
        logic prev_f_hs;
        logic ce;
        run_s = 0; max_s = 0; run_f = 0; max_f = 0;
        mode = 1'b0;
        do_reset();
        prev_f_hs = f_hs;
        for (int c = 0; c < 900 * 4; c++) begin
            ce = (c % 4 == 0);
            tick(ce);
            n_tests++;
            if ({s_hs[1], s_vs[1], s_rgb[1], s_fs[1]} !== {e_out[1], ce && mh == 0 && mv == 0}) begin
                n_fail++;
                $display("FAIL ce_outputs clk %0d: hs=%b vs=%b rgb=%h fs=%b want %b fs=%b",
                         c, s_hs[1], s_vs[1], s_rgb[1], s_fs[1], e_out[1], ce && mh == 0 && mv == 0);
            end
            n_tests++;
            if (!ce && (f_hs !== prev_f_hs || f_fs !== 1'b0)) begin
                n_fail++;
                $display("FAIL ce_hold_full clk %0d: hs=%b prev=%b fs=%b", c, f_hs, prev_f_hs, f_fs);
            end
            prev_f_hs = f_hs;
            run_s = s_hs[1] ? 0 : run_s + 1;
            run_f = f_hs ? 0 : run_f + 1;
            if (run_s > max_s) max_s = run_s;
            if (run_f > max_f) max_f = run_f;
        end
        n_tests++;
        if (max_s != HSY * 4 || max_f != 384) begin
            n_fail++;
            $display("FAIL ce_hsync_width: small=%0d full=%0d, want %0d 384", max_s, max_f, HSY * 4);
        end
    endtask

    task automatic test_wrap();
        mode = 1'b0;
        do_reset();
        repeat (HT * VT - 1) tick(1'b1);
        n_tests++;
        if ({s_vb[1], s_act[1], s_x[1], s_y[1], s_fs[1]} !== {1'b1, 1'b0, 10'd0, 9'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_last: vb=%b act=%b x=%0d y=%0d fs=%b, want 1 0 0 0 0",
                     s_vb[1], s_act[1], s_x[1], s_y[1], s_fs[1]);
        end
        tick(1'b1);
        n_tests++;
        if ({s_vb[1], s_act[1], s_x[1], s_y[1], s_fs[1]} !== {1'b0, 1'b1, 10'd0, 9'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL wrap_first: vb=%b act=%b x=%0d y=%0d fs=%b, want 0 1 0 0 1",
                     s_vb[1], s_act[1], s_x[1], s_y[1], s_fs[1]);
        end
        tick(1'b1);
        n_tests++;
        if ({s_x[1], s_fs[1]} !== {10'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL wrap_next: x=%0d fs=%b, want 1 0", s_x[1], s_fs[1]);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mode    = 1'b0;
        rst     = 1'b1;
        pix_ce  = 1'b0;
        mh      = 0;
        mv      = 0;
        for (int g = 0; g < 3; g++) e_out[g] = 8'hC0;
        #2;
        test_reset();
        test_frame_timing();
        test_alignment();
        test_blanking();
        test_clock_enable();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
